// File: rtl/cnter_wrap_monitor_if.sv
// Bundle of the counter, threshold and snapshot-handshake signals
// between the wrap monitor and whatever drives and consumes it.
interface cnter_wrap_monitor_if #(
  parameter int WRAP_W = 8
);
  logic              en;
  logic [1:0]        cnter_in;
  logic              cnter_clr;
  logic [WRAP_W-1:0] thresh;
  logic              snap_req;
  logic              snap_ack;
  logic              wrap_pulse;
  logic              thresh_hit;
  logic              seq_err;
  logic              snap_valid;
  logic [WRAP_W-1:0] snap_wraps;

  modport master (
    output en, cnter_in, cnter_clr, thresh, snap_req, snap_ack,
    input  wrap_pulse, thresh_hit, seq_err, snap_valid, snap_wraps
  );

  modport slave (
    input  en, cnter_in, cnter_clr, thresh, snap_req, snap_ack,
    output wrap_pulse, thresh_hit, seq_err, snap_valid, snap_wraps
  );
endinterface

// File: rtl/cnter_wrap_monitor.sv
// Watches the free-running 2-bit cycle counter, flags illegal steps,
// counts 3->0 wraps in a saturating accumulator and hands the count
// out through a req/valid/ack snapshot handshake.
//
// state | meaning
// IDLE  | no snapshot outstanding, snap_req is accepted
// HOLD  | snapshot valid and frozen, waiting for snap_ack
module cnter_wrap_monitor #(
  parameter int WRAP_W = 8
) (
  input logic              clk,
  input logic              rst,
  cnter_wrap_monitor_if.slave bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [WRAP_W-1:0] WRAPS_MAX = '1;
  localparam logic [WRAP_W-1:0] WRAPS_ONE = {{(WRAP_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [1:0]        prev;
  logic              prev_vld;
  logic              clr_d;
  logic [WRAP_W-1:0] wraps_cnt;
  logic [WRAP_W-1:0] wraps_nxt;
  logic [WRAP_W-1:0] snap_wraps_q;
  logic              wrap_pulse_q;
  logic              thresh_hit_q;
  logic              seq_err_q;
  logic              check;
  logic              is_clear;
  logic              is_wrap;
  logic              is_incr;
  logic              wrap;
  logic              illegal;
  logic              capture;

  // Classify the current step against the previous sample; a saturating
  // increment is precomputed so a coincident capture can include it.
  always_comb begin
    check     = bus.en && prev_vld;
    is_clear  = clr_d && (bus.cnter_in == 2'd0);
    is_wrap   = !clr_d && (prev == 2'd3) && (bus.cnter_in == 2'd0);
    is_incr   = !clr_d && (prev != 2'd3) && (bus.cnter_in == prev + 2'd1);
    wrap      = check && is_wrap;
    illegal   = check && !(is_clear || is_wrap || is_incr);
    wraps_nxt = (wrap && (wraps_cnt != WRAPS_MAX)) ? wraps_cnt + WRAPS_ONE
                                                   : wraps_cnt;
  end

  // Sample history; dropping en forgets it so re-enable resynchronises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev     <= 2'd0;
      prev_vld <= 1'b0;
      clr_d    <= 1'b0;
    end else if (bus.en) begin
      prev     <= bus.cnter_in;
      clr_d    <= bus.cnter_clr;
      prev_vld <= 1'b1;
    end else begin
      prev_vld <= 1'b0;
      clr_d    <= 1'b0;
    end
  end

  // Snapshot FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Snapshot FSM next state; capture marks the IDLE->HOLD edge.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: if (bus.snap_req) begin
        capture   = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: if (bus.snap_ack) state_nxt = IDLE;
    endcase
  end

  // Accumulator, sticky flags and snapshot register; a capture restarts
  // the count and clears thresh_hit ahead of any new threshold match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wraps_cnt    <= '0;
      snap_wraps_q <= '0;
      wrap_pulse_q <= 1'b0;
      thresh_hit_q <= 1'b0;
      seq_err_q    <= 1'b0;
    end else begin
      wrap_pulse_q <= wrap;
      seq_err_q    <= seq_err_q | illegal;
      if (capture) begin
        snap_wraps_q <= wraps_nxt;
        wraps_cnt    <= '0;
        thresh_hit_q <= 1'b0;
      end else begin
        wraps_cnt <= wraps_nxt;
        if (bus.en && (bus.thresh != '0) && (wraps_nxt >= bus.thresh))
          thresh_hit_q <= 1'b1;
      end
    end
  end

  assign bus.wrap_pulse = wrap_pulse_q;
  assign bus.thresh_hit = thresh_hit_q;
  assign bus.seq_err    = seq_err_q;
  assign bus.snap_valid = (state == HOLD);
  assign bus.snap_wraps = snap_wraps_q;

endmodule

// File: tb/tb_cnter_wrap_monitor.sv
// Directed bench for the wrap monitor: one 8-bit instance for the main
// sequences and one 2-bit instance for saturation and resync.
module tb_cnter_wrap_monitor;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  cnter_wrap_monitor_if #(.WRAP_W(8)) a_if ();
  cnter_wrap_monitor_if #(.WRAP_W(2)) b_if ();

  cnter_wrap_monitor #(.WRAP_W(8)) dut_a (.clk(clk), .rst(rst), .bus(a_if));
  cnter_wrap_monitor #(.WRAP_W(2)) dut_b (.clk(clk), .rst(rst), .bus(b_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_a(input logic [1:0] cin, input logic clr,
                         input logic req, input logic ack);
    a_if.cnter_in  = cin;
    a_if.cnter_clr = clr;
    a_if.snap_req  = req;
    a_if.snap_ack  = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic [1:0] cin, input logic req);
    b_if.cnter_in = cin;
    b_if.snap_req = req;
    @(posedge clk);
    #1;
  endtask

  int t_vals [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1;
    a_if.en = 0; a_if.cnter_in = 0; a_if.cnter_clr = 0; a_if.thresh = 0;
    a_if.snap_req = 0; a_if.snap_ack = 0;
    b_if.en = 0; b_if.cnter_in = 0; b_if.cnter_clr = 0; b_if.thresh = 0;
    b_if.snap_req = 0; b_if.snap_ack = 0;
    @(posedge clk); @(posedge clk); #1;
    check_val("rst_wrap_pulse", a_if.wrap_pulse, 0);
    check_val("rst_thresh_hit", a_if.thresh_hit, 0);
    check_val("rst_seq_err", a_if.seq_err, 0);
    check_val("rst_snap_valid", a_if.snap_valid, 0);
    check_val("rst_snap_wraps", a_if.snap_wraps, 0);
    rst = 1'b0;

    // two wraps over 0..3,0..3,0
    a_if.en = 1;
    for (int i = 0; i < 9; i++) begin
      drive_a(t_vals[i][1:0], 0, 0, 0);
      check_val($sformatf("t1_pulse_%0d", i), a_if.wrap_pulse,
                (i == 4 || i == 8) ? 1 : 0);
    end
    check_val("t1_seq_err", a_if.seq_err, 0);
    check_val("t1_thresh_hit", a_if.thresh_hit, 0);

    // synchronous clear 2->0 is legal and not a wrap
    drive_a(1, 0, 0, 0);
    drive_a(2, 1, 0, 0);
    drive_a(0, 0, 0, 0);
    check_val("t2_clear_no_pulse", a_if.wrap_pulse, 0);
    drive_a(1, 0, 0, 0);
    check_val("t2_clear_seq_err", a_if.seq_err, 0);

    // drain the two wraps so far
    drive_a(2, 0, 1, 0);
    check_val("t2_snap_valid", a_if.snap_valid, 1);
    check_val("t2_snap_wraps", a_if.snap_wraps, 2);
    drive_a(3, 0, 0, 1);
    check_val("t2_ack_valid", a_if.snap_valid, 0);

    // threshold 3 reached on the third wrap
    a_if.thresh = 3;
    for (int i = 0; i < 9; i++) begin
      drive_a(t_vals[i][1:0], 0, 0, 0);
      check_val($sformatf("t3_thresh_%0d", i), a_if.thresh_hit,
                (i == 8) ? 1 : 0);
    end
    drive_a(1, 0, 1, 0);
    check_val("t3_snap_wraps", a_if.snap_wraps, 3);
    check_val("t3_snap_valid", a_if.snap_valid, 1);
    check_val("t3_thresh_cleared", a_if.thresh_hit, 0);
    a_if.thresh = 0;
    drive_a(2, 0, 0, 1);
    check_val("t3_ack_valid", a_if.snap_valid, 0);

    // four wraps, then a capture coincident with the fifth
    for (int k = 0; k < 4; k++) begin
      drive_a(3, 0, 0, 0); drive_a(0, 0, 0, 0);
      drive_a(1, 0, 0, 0); drive_a(2, 0, 0, 0);
    end
    drive_a(3, 0, 0, 0);
    drive_a(0, 0, 1, 0);
    check_val("t4_coinc_pulse", a_if.wrap_pulse, 1);
    check_val("t4_coinc_snap", a_if.snap_wraps, 5);
    for (int k = 0; k < 2; k++) begin
      drive_a(1, 0, 1, 0); drive_a(2, 0, 1, 0);
      drive_a(3, 0, 1, 0); drive_a(0, 0, 1, 0);
    end
    check_val("t4_hold_snap", a_if.snap_wraps, 5);
    check_val("t4_hold_valid", a_if.snap_valid, 1);
    drive_a(1, 0, 0, 1);
    check_val("t4_ack_valid", a_if.snap_valid, 0);
    drive_a(2, 0, 1, 0);
    check_val("t4_next_snap", a_if.snap_wraps, 2);
    drive_a(3, 0, 0, 1);

    // illegal 1->3 step is sticky; capture beats a threshold match
    a_if.thresh = 1;
    drive_a(0, 0, 0, 0);
    check_val("t5_thresh_hit", a_if.thresh_hit, 1);
    drive_a(1, 0, 0, 0);
    drive_a(3, 0, 0, 0);
    check_val("t5_seq_err", a_if.seq_err, 1);
    drive_a(0, 0, 0, 0);
    drive_a(1, 0, 0, 0);
    check_val("t5_seq_sticky", a_if.seq_err, 1);
    drive_a(2, 0, 1, 0);
    check_val("t5_cap_thresh", a_if.thresh_hit, 0);
    check_val("t5_cap_snap", a_if.snap_wraps, 2);
    drive_a(3, 0, 0, 0);
    drive_a(0, 0, 0, 0);
    check_val("t5_pre_rst_valid", a_if.snap_valid, 1);
    check_val("t5_pre_rst_thresh", a_if.thresh_hit, 1);

    // asynchronous reset in HOLD, between clock edges
    #2;
    rst = 1'b1;
    #1;
    check_val("t6_async_pulse", a_if.wrap_pulse, 0);
    check_val("t6_async_thresh", a_if.thresh_hit, 0);
    check_val("t6_async_seq_err", a_if.seq_err, 0);
    check_val("t6_async_valid", a_if.snap_valid, 0);
    check_val("t6_async_snap", a_if.snap_wraps, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    a_if.thresh = 0;
    drive_a(2, 0, 0, 0);
    check_val("t6_first_unchecked", a_if.seq_err, 0);
    drive_a(3, 0, 0, 0);
    drive_a(0, 0, 1, 0);
    check_val("t6_idle_capture", a_if.snap_valid, 1);
    check_val("t6_capture_wraps", a_if.snap_wraps, 1);
    check_val("t6_seq_err", a_if.seq_err, 0);
    drive_a(1, 0, 0, 1);
    a_if.en = 0;

    // 2-bit accumulator saturates at 3; en gap then resync at 2
    b_if.en = 1;
    for (int i = 0; i < 20; i++) drive_b(2'(i % 4), 0);
    b_if.en = 0;
    drive_b(1, 0);
    b_if.en = 1;
    drive_b(2, 0);
    check_val("b_resync_seq_err", b_if.seq_err, 0);
    drive_b(3, 0);
    drive_b(0, 1);
    check_val("b_sat_snap", b_if.snap_wraps, 3);
    check_val("b_sat_valid", b_if.snap_valid, 1);
    check_val("b_seq_err", b_if.seq_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cnter_wrap_monitor.md
Name: cnter_wrap_monitor

Overview:
- Downstream consumer of the free-running 2-bit cycle counter (cnter) and its synchronous clear sideband (rst_cnter).
- Checks that every sampled counter step is legal and counts 3->0 wraps in a WRAP_W-bit saturating accumulator.
- Raises a threshold flag and hands the wrap count to software/upstream logic through a req/valid/ack snapshot handshake.

Parameters:
- WRAP_W, 8, width of the wrap accumulator and snapshot bus (>=2)

Ports:
- clk  input  1  clock; all state updates on the posedge
- rst  input  1  asynchronous, active-high reset
- en  input  1  monitor enable; 0 = no sampling, resync on re-enable
- cnter_in  input  2  counter value from the upstream counter
- cnter_clr  input  1  copy of upstream rst_cnter; counter reads 0 on the next cycle
- thresh  input  WRAP_W  wrap threshold; 0 disables thresh_hit
- snap_req  input  1  snapshot request, sampled in IDLE only
- snap_ack  input  1  consumer accepts snapshot
- wrap_pulse  output  1  one-cycle pulse per detected wrap
- thresh_hit  output  1  sticky, wraps_cnt >= thresh
- seq_err  output  1  sticky, illegal counter step seen
- snap_valid  output  1  snapshot data held valid
- snap_wraps  output  WRAP_W  captured wrap count

Behaviour:
- Reset (async, rst=1): prev=0, prev_vld=0, clr_d=0, wraps_cnt=0, and all outputs 0. FSM goes to IDLE. Applies immediately, including mid-handshake; a pending snapshot is discarded.
- Sampling, at each posedge with en=1:
  - prev<=cnter_in
  - clr_d<=cnter_clr
  - prev_vld<=1
- en=0 at an edge: prev_vld<=0, clr_d<=0. No checks or counts. Accumulator and flags are held.
- Step classification (combinational, only when en=1 and prev_vld=1):
  - clear: clr_d=1 and cnter_in=0. Legal; not a wrap, even if prev=3.
  - wrap: clr_d=0, prev=3, cnter_in=0.
  - incr: clr_d=0, cnter_in=prev+1 (mod 4), prev!=3.
  - anything else, including hold or skip: illegal. seq_err<=1 (sticky until rst).
- The first enabled sample (prev_vld=0) is never checked.
- wrap_pulse is registered: high for exactly the cycle after the edge at which the wrap was classified.
- wraps_cnt increments by 1 on each wrap. It saturates at 2^WRAP_W-1 (no roll-over).
- thresh_hit<=1 at the edge where the updated wraps_cnt >= thresh and thresh!=0. Sticky until a snapshot capture or rst.
- Snapshot FSM, states IDLE and HOLD:
  - IDLE, snap_req=1 at edge: snap_wraps<=wraps_cnt + (wrap this cycle, saturated). wraps_cnt<=0, thresh_hit<=0, snap_valid<=1, go to HOLD. A coincident wrap goes into the snapshot, not the new count. wrap_pulse still fires.
  - HOLD: snap_wraps and snap_valid are stable. Accumulation continues. snap_req is ignored.
  - HOLD, snap_ack=1 at edge: snap_valid<=0, go to IDLE. A new req can be taken at the following edge.
  - snap_ack in IDLE is ignored.
- thresh set while a capture clears thresh_hit in the same edge: the capture wins and thresh_hit=0. Re-evaluation starts from the new count.
- Latency: cnter_in at edge k to wrap_pulse/wraps_cnt/seq_err visible after edge k (one cycle).

Test Plan:
- Reset, en=1, cnter_in 0,1,2,3,0,1,2,3,0, thresh=0 -> wrap_pulse high for 1 cycle after each 3->0 edge (2 pulses). seq_err=0. thresh_hit=0.
- cnter_in 1,2 with cnter_clr=1 on the "2" sample, then 0,1 -> classified as clear, no wrap_pulse, seq_err=0. Separately 1,3 -> seq_err=1 and it remains set through further legal steps.
- thresh=3, run 3 full wraps -> thresh_hit rises at the edge of the 3rd wrap. snap_req -> snap_valid=1, snap_wraps=3, thresh_hit=0, wraps_cnt=0.
- snap_req on the same edge as a wrap with wraps_cnt=4 -> snap_wraps=5, wraps_cnt=0. Two more wraps during HOLD with snap_req held -> snap_wraps stays 5. snap_ack -> snap_valid=0. Next req captures 2.
- WRAP_W=2: 5 wraps -> wraps_cnt saturates at 3. Toggling en=0 for 1 cycle, then resuming at an arbitrary value (2) -> no seq_err on the resync sample.
- Assert rst asynchronously mid-HOLD with seq_err=1 -> all outputs 0 immediately, not waiting for a clock edge. After release, the FSM is in IDLE and the first sample is unchecked.
